// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing generator with a frame-synchronous config
// shadow, pixel clock enable and fully registered, zero-skew outputs.
module vga_timing_gen #(
  parameter int              W       = 12,
  parameter logic [4*W-1:0]  DEF_H   = {12'd16, 12'd640, 12'd48, 12'd96},
  parameter logic [4*W-1:0]  DEF_V   = {12'd10, 12'd480, 12'd33, 12'd2},
  parameter logic [1:0]      DEF_POL = 2'b00
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           en,
  input  logic [4*W-1:0] cfg_h,
  input  logic [4*W-1:0] cfg_v,
  input  logic [1:0]     cfg_pol,
  input  logic           cfg_valid,
  output logic           cfg_ack,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [W-1:0]   x,
  output logic [W-1:0]   y,
  output logic [W-1:0]   hcount,
  output logic [W-1:0]   vcount,
  output logic           line_start,
  output logic           frame_start
);

  function automatic logic [W-1:0] f_sync(input logic [4*W-1:0] t);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] f_bp(input logic [4*W-1:0] t);
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] f_act(input logic [4*W-1:0] t);
    return t[3*W-1:2*W];
  endfunction

  function automatic logic [W-1:0] f_fp(input logic [4*W-1:0] t);
    return t[4*W-1:3*W];
  endfunction

  function automatic logic [W-1:0] f_total(input logic [4*W-1:0] t);
    return f_sync(t) + f_bp(t) + f_act(t) + f_fp(t);
  endfunction

  function automatic logic f_in_act(input logic [W-1:0] c, input logic [4*W-1:0] t);
    return (c >= f_sync(t) + f_bp(t)) && (c < f_sync(t) + f_bp(t) + f_act(t));
  endfunction

  logic [4*W-1:0] cur_h_q, cur_h_d, cur_v_q, cur_v_d;
  logic [4*W-1:0] shd_h_q, shd_h_d, shd_v_q, shd_v_d;
  logic [4*W-1:0] src_h, src_v;
  logic [1:0]     cur_pol_q, cur_pol_d, shd_pol_q, shd_pol_d, src_pol;
  logic           pending_q, pending_d, run_q, run_d;
  logic           h_last, v_last, at_end, apply;

  logic [W-1:0]   hcount_q, hcount_d, vcount_q, vcount_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic           hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic           line_q, line_d, frame_q, frame_d, ack_q;
  logic           h_on, v_on;

  // Config shadow; a write landing on the apply edge bypasses the shadow.
  always_comb begin
    src_h     = cfg_valid ? cfg_h   : shd_h_q;
    src_v     = cfg_valid ? cfg_v   : shd_v_q;
    src_pol   = cfg_valid ? cfg_pol : shd_pol_q;
    h_last    = hcount_q >= f_total(cur_h_q) - 1'b1;
    v_last    = vcount_q >= f_total(cur_v_q) - 1'b1;
    at_end    = en & ce & run_q & h_last & v_last;
    apply     = (~en | at_end) & (pending_q | cfg_valid);
    cur_h_d   = apply ? src_h   : cur_h_q;
    cur_v_d   = apply ? src_v   : cur_v_q;
    cur_pol_d = apply ? src_pol : cur_pol_q;
    shd_h_d   = cfg_valid ? cfg_h   : shd_h_q;
    shd_v_d   = cfg_valid ? cfg_v   : shd_v_q;
    shd_pol_d = cfg_valid ? cfg_pol : shd_pol_q;
    if (apply)          pending_d = 1'b0;
    else if (cfg_valid) pending_d = 1'b1;
    else                pending_d = pending_q;
  end

  // Outputs are decoded from the next count with the next timing, so after
  // the register they describe exactly the count they sit beside.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    run_d    = run_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    de_d     = de_q;
    x_d      = x_q;
    y_d      = y_q;
    line_d   = line_q;
    frame_d  = frame_q;
    h_on     = 1'b0;
    v_on     = 1'b0;
    if (!en) begin
      hcount_d = '0;
      vcount_d = '0;
      run_d    = 1'b0;
      hsync_d  = ~cur_pol_d[0];
      vsync_d  = ~cur_pol_d[1];
      de_d     = 1'b0;
      x_d      = '0;
      y_d      = '0;
      line_d   = 1'b0;
      frame_d  = 1'b0;
    end else if (ce) begin
      run_d = 1'b1;
      if (!run_q) begin
        hcount_d = '0;
        vcount_d = '0;
      end else if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
      h_on    = f_in_act(hcount_d, cur_h_d);
      v_on    = f_in_act(vcount_d, cur_v_d);
      hsync_d = (hcount_d < f_sync(cur_h_d)) ~^ cur_pol_d[0];
      vsync_d = (vcount_d < f_sync(cur_v_d)) ~^ cur_pol_d[1];
      de_d    = h_on & v_on;
      x_d     = (h_on & v_on) ? hcount_d - f_sync(cur_h_d) - f_bp(cur_h_d) : '0;
      y_d     = v_on ? vcount_d - f_sync(cur_v_d) - f_bp(cur_v_d) : '0;
      line_d  = (hcount_d == '0);
      frame_d = (hcount_d == '0) && (vcount_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_h_q   <= DEF_H;
      cur_v_q   <= DEF_V;
      cur_pol_q <= DEF_POL;
      shd_h_q   <= DEF_H;
      shd_v_q   <= DEF_V;
      shd_pol_q <= DEF_POL;
      pending_q <= 1'b0;
      run_q     <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hsync_q   <= ~DEF_POL[0];
      vsync_q   <= ~DEF_POL[1];
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      cur_h_q   <= cur_h_d;
      cur_v_q   <= cur_v_d;
      cur_pol_q <= cur_pol_d;
      shd_h_q   <= shd_h_d;
      shd_v_q   <= shd_v_d;
      shd_pol_q <= shd_pol_d;
      pending_q <= pending_d;
      run_q     <= run_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      ack_q     <= apply;
    end
  end

  assign cfg_ack     = ack_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule
